// File: rtl/dual_slope_adc_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : dual_slope_adc_ctrl                                      |
// | Description : Dual-slope ADC conversion controller. Sequences the      |
// |               analog front end through integrator reset, fixed-time    |
// |               integrate of Vin and timed deintegrate against Vref,     |
// |               then latches the count and raises a sticky interrupt.    |
// | Options     : DUAL_SLOPE_COMP_SYNC_EN - 2-flop comparator synchronizer |
// |               (result then carries the raw +2 cycle latency)           |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module dual_slope_adc_ctrl #(
  parameter int CNT_W      = 12,
  parameter int INT_CYCLES = 2048,
  parameter int RST_CYCLES = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             comp_i,
  input  logic             analog_ready_i,
  input  logic             trigger_i,
  input  logic             interrupt_clear_i,
  input  logic             deintegrate_i,
  output logic             reset_int_o,
  output logic             integrate_o,
  output logic             deintegrate_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] result_o,
  output logic             result_valid_o,
  output logic             overflow_o,
  output logic             interrupt_o
);

  // Terminal counts: each phase ends on the cycle whose count equals these.
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] INT_LAST = CNT_W'(INT_CYCLES - 1);
  localparam logic [CNT_W-1:0] FULL     = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_RDY  = 3'd1,
    S_ZERO      = 3'd2,
    S_INTEGRATE = 3'd3,
    S_DEINT     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] result_nxt;
  logic             overflow_nxt;
  logic             irq_nxt;
  logic             comp_s;

`ifdef DUAL_SLOPE_COMP_SYNC_EN
  logic [1:0] comp_sync;

  // Two-stage synchronizer; idles high so a reset never looks like a trip.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) comp_sync <= 2'b11;
    else          comp_sync <= {comp_sync[0], comp_i};
  end

  assign comp_s = comp_sync[1];
`else
  assign comp_s = comp_i;
`endif

  // Next-state, counter and result logic; abort on loss of analog ready wins.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    result_nxt   = result_o;
    overflow_nxt = overflow_o;
    irq_nxt      = interrupt_o;
    case (state)
      S_IDLE: begin
        if (trigger_i) state_nxt = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (analog_ready_i) begin
          state_nxt = S_ZERO;
          cnt_nxt   = '0;
        end
      end
      S_ZERO: begin
        if (!analog_ready_i) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == RST_LAST) begin
          state_nxt = S_INTEGRATE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_INTEGRATE: begin
        if (!analog_ready_i) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (deintegrate_i || (cnt == INT_LAST)) begin
          state_nxt = S_DEINT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DEINT: begin
        if (!analog_ready_i) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (!comp_s) begin
          state_nxt    = S_DONE;
          result_nxt   = cnt;
          overflow_nxt = 1'b0;
          irq_nxt      = 1'b1;
        end else if (cnt == FULL) begin
          state_nxt    = S_DONE;
          result_nxt   = FULL;
          overflow_nxt = 1'b1;
          irq_nxt      = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (interrupt_clear_i) begin
          state_nxt = S_IDLE;
          irq_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; controls decoded from next state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state          <= S_IDLE;
      cnt            <= '0;
      reset_int_o    <= 1'b0;
      integrate_o    <= 1'b0;
      deintegrate_o  <= 1'b0;
      busy_o         <= 1'b0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
      overflow_o     <= 1'b0;
      interrupt_o    <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      reset_int_o    <= (state_nxt == S_ZERO);
      integrate_o    <= (state_nxt == S_INTEGRATE);
      deintegrate_o  <= (state_nxt == S_DEINT);
      busy_o         <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      result_o       <= result_nxt;
      result_valid_o <= (state_nxt == S_DONE) && (state != S_DONE);
      overflow_o     <= overflow_nxt;
      interrupt_o    <= irq_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dual_slope_adc_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_dual_slope_adc_ctrl                                   |
// | Description : Directed self-checking bench for dual_slope_adc_ctrl     |
// |               (CNT_W=8, INT_CYCLES=16, RST_CYCLES=4, no synchronizer). |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_dual_slope_adc_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       comp_i;
  logic       analog_ready_i;
  logic       trigger_i;
  logic       interrupt_clear_i;
  logic       deintegrate_i;
  logic       reset_int_o;
  logic       integrate_o;
  logic       deintegrate_o;
  logic       busy_o;
  logic [7:0] result_o;
  logic       result_valid_o;
  logic       overflow_o;
  logic       interrupt_o;

  int errors = 0;
  int checks = 0;

  dual_slope_adc_ctrl #(
    .CNT_W      (8),
    .INT_CYCLES (16),
    .RST_CYCLES (4)
  ) dut (
    .clk_i             (clk_i),
    .rst_n_i           (rst_n_i),
    .comp_i            (comp_i),
    .analog_ready_i    (analog_ready_i),
    .trigger_i         (trigger_i),
    .interrupt_clear_i (interrupt_clear_i),
    .deintegrate_i     (deintegrate_i),
    .reset_int_o       (reset_int_o),
    .integrate_o       (integrate_o),
    .deintegrate_o     (deintegrate_o),
    .busy_o            (busy_o),
    .result_o          (result_o),
    .result_valid_o    (result_valid_o),
    .overflow_o        (overflow_o),
    .interrupt_o       (interrupt_o)
  );

  // 100 MHz clock.
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [14:0] all_outs();
    return {reset_int_o, integrate_o, deintegrate_o, busy_o,
            result_valid_o, overflow_o, interrupt_o, result_o};
  endfunction

  // Runs one conversion, counting phase lengths; returns in the first DONE cycle.
  // comp_i drops during DEINT cycle drop_at (0 = never); deintegrate_i is
  // raised during INTEGRATE cycle early_at (0 = never).
  task automatic run_conv(input int drop_at, input int early_at, input logic hold_trig,
                          output int n_zero, output int n_int, output int n_deint,
                          output logic [7:0] res, output logic ovf, output logic irq,
                          output logic handoff_ok, output logic timed_out);
    logic prev_int;
    n_zero = 0; n_int = 0; n_deint = 0; res = '0; ovf = 1'b0; irq = 1'b0;
    handoff_ok = 1'b1; timed_out = 1'b1; prev_int = 1'b0;
    trigger_i = 1'b1;
    step();
    if (!hold_trig) trigger_i = 1'b0;
    for (int c = 0; c < 700; c++) begin
      deintegrate_i = 1'b0;
      if (reset_int_o) n_zero++;
      if (integrate_o) begin
        n_int++;
        if (n_int == early_at) deintegrate_i = 1'b1;
      end
      if (prev_int && !integrate_o && !deintegrate_o) handoff_ok = 1'b0;
      prev_int = integrate_o;
      if (deintegrate_o) begin
        n_deint++;
        if (n_deint == drop_at) comp_i = 1'b0;
      end
      if (result_valid_o) begin
        res = result_o; ovf = overflow_o; irq = interrupt_o;
        timed_out = 1'b0;
        break;
      end
      step();
    end
    comp_i = 1'b1;
    deintegrate_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    comp_i = 1'b1; analog_ready_i = 1'b1; trigger_i = 1'b0;
    interrupt_clear_i = 1'b0; deintegrate_i = 1'b0;
    step(); step();
    checks++;
    if (all_outs() !== 15'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", all_outs(), 15'h0);
    end
    rst_n_i = 1'b1;
    step(); step();
    checks++;
    if (all_outs() !== 15'h0) begin
      errors++; $display("FAIL idle_after_reset: got %h expected %h", all_outs(), 15'h0);
    end
  endtask

  task automatic test_normal();
    int nz, ni, nd; logic [7:0] r; logic o, q, h, t;
    logic held;
    run_conv(11, 0, 1'b0, nz, ni, nd, r, o, q, h, t);
    checks++; if (t !== 1'b0) begin errors++; $display("FAIL normal_timeout: got %0d expected %0d", t, 0); end
    checks++; if (nz !== 4)   begin errors++; $display("FAIL normal_zero_len: got %0d expected %0d", nz, 4); end
    checks++; if (ni !== 16)  begin errors++; $display("FAIL normal_int_len: got %0d expected %0d", ni, 16); end
    checks++; if (nd !== 11)  begin errors++; $display("FAIL normal_deint_len: got %0d expected %0d", nd, 11); end
    checks++; if (r !== 8'd10) begin errors++; $display("FAIL normal_result: got %0d expected %0d", r, 10); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL normal_overflow: got %0d expected %0d", o, 0); end
    checks++; if (q !== 1'b1) begin errors++; $display("FAIL normal_irq_set: got %0d expected %0d", q, 1); end
    step();
    checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL valid_one_cycle: got %0d expected %0d", result_valid_o, 0); end
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (interrupt_o !== 1'b1 || busy_o !== 1'b0) held = 1'b0;
      step();
    end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL irq_held: got %0d expected %0d", held, 1); end
    interrupt_clear_i = 1'b1;
    step();
    interrupt_clear_i = 1'b0;
    checks++; if (interrupt_o !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %0d expected %0d", interrupt_o, 0); end
    step(); step();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL idle_after_clear: got %0d expected %0d", busy_o, 0); end
  endtask

  task automatic test_overflow();
    int nz, ni, nd; logic [7:0] r; logic o, q, h, t;
    run_conv(0, 0, 1'b0, nz, ni, nd, r, o, q, h, t);
    checks++; if (t !== 1'b0)   begin errors++; $display("FAIL ovf_timeout: got %0d expected %0d", t, 0); end
    checks++; if (nd !== 256)   begin errors++; $display("FAIL ovf_deint_len: got %0d expected %0d", nd, 256); end
    checks++; if (r !== 8'd255) begin errors++; $display("FAIL ovf_result: got %0d expected %0d", r, 255); end
    checks++; if (o !== 1'b1)   begin errors++; $display("FAIL ovf_flag: got %0d expected %0d", o, 1); end
    checks++; if (q !== 1'b1)   begin errors++; $display("FAIL ovf_irq: got %0d expected %0d", q, 1); end
    interrupt_clear_i = 1'b1;
    step();
    interrupt_clear_i = 1'b0;
    step();
  endtask

  task automatic test_abort();
    int n_int; logic reached; logic quiet;
    n_int = 0; reached = 1'b0;
    trigger_i = 1'b1;
    step();
    trigger_i = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (integrate_o) begin
        n_int++;
        if (n_int == 7) begin
          analog_ready_i = 1'b0;
          reached = 1'b1;
          break;
        end
      end
      step();
    end
    checks++; if (reached !== 1'b1) begin errors++; $display("FAIL abort_reach_int7: got %0d expected %0d", reached, 1); end
    step();
    checks++;
    if ({reset_int_o, integrate_o, deintegrate_o, busy_o} !== 4'b0000) begin
      errors++; $display("FAIL abort_controls: got %b expected %b",
                         {reset_int_o, integrate_o, deintegrate_o, busy_o}, 4'b0000);
    end
    checks++; if (result_o !== 8'd255) begin errors++; $display("FAIL abort_result_kept: got %0d expected %0d", result_o, 255); end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL abort_ovf_kept: got %0d expected %0d", overflow_o, 1); end
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (result_valid_o || interrupt_o || busy_o) quiet = 1'b0;
      step();
    end
    checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL abort_no_result: got %0d expected %0d", quiet, 1); end
    analog_ready_i = 1'b1;
    step();
  endtask

  task automatic test_early_deint();
    int nz, ni, nd; logic [7:0] r; logic o, q, h, t;
    run_conv(3, 5, 1'b0, nz, ni, nd, r, o, q, h, t);
    checks++; if (t !== 1'b0)  begin errors++; $display("FAIL early_timeout: got %0d expected %0d", t, 0); end
    checks++; if (ni !== 5)    begin errors++; $display("FAIL early_int_len: got %0d expected %0d", ni, 5); end
    checks++; if (h !== 1'b1)  begin errors++; $display("FAIL early_handoff: got %0d expected %0d", h, 1); end
    checks++; if (r !== 8'd2)  begin errors++; $display("FAIL early_result: got %0d expected %0d", r, 2); end
    checks++; if (o !== 1'b0)  begin errors++; $display("FAIL early_ovf: got %0d expected %0d", o, 0); end
    interrupt_clear_i = 1'b1;
    step();
    interrupt_clear_i = 1'b0;
    step();
  endtask

  task automatic test_busy_done();
    int nz, ni, nd; logic [7:0] r; logic o, q, h, t;
    run_conv(4, 0, 1'b1, nz, ni, nd, r, o, q, h, t);
    checks++; if (t !== 1'b0)  begin errors++; $display("FAIL busy_timeout: got %0d expected %0d", t, 0); end
    checks++; if (nz !== 4)    begin errors++; $display("FAIL busy_no_restart: got %0d expected %0d", nz, 4); end
    checks++; if (r !== 8'd3)  begin errors++; $display("FAIL busy_result: got %0d expected %0d", r, 3); end
    interrupt_clear_i = 1'b1;
    step();
    interrupt_clear_i = 1'b0;
    checks++;
    if ({busy_o, interrupt_o} !== 2'b00) begin
      errors++; $display("FAIL clear_wins: got %b expected %b", {busy_o, interrupt_o}, 2'b00);
    end
    step();
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL restart_busy: got %0d expected %0d", busy_o, 1); end
    step();
    trigger_i = 1'b0;
    checks++; if (reset_int_o !== 1'b1) begin errors++; $display("FAIL restart_zero: got %0d expected %0d", reset_int_o, 1); end
  endtask

  task automatic test_async_reset();
    int nd; logic got_deint;
    nd = 0; got_deint = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (deintegrate_o) nd++;
      if (nd == 3) begin got_deint = 1'b1; break; end
      step();
    end
    checks++; if (got_deint !== 1'b1) begin errors++; $display("FAIL reach_deint: got %0d expected %0d", got_deint, 1); end
    #2;
    rst_n_i = 1'b0;
    #1;
    checks++;
    if (all_outs() !== 15'h0) begin
      errors++; $display("FAIL async_reset: got %h expected %h", all_outs(), 15'h0);
    end
    step();
    rst_n_i = 1'b1;
    step(); step();
    checks++;
    if (all_outs() !== 15'h0) begin
      errors++; $display("FAIL idle_after_async_reset: got %h expected %h", all_outs(), 15'h0);
    end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_normal();
    test_overflow();
    test_abort();
    test_early_deint();
    test_busy_done();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
